// File: rtl/l1d_refill_mem_ctrl.sv
// Main-memory side controller for the L1D: serves 4-word line fills and write-backs
// from an internal word array with a fixed access latency.
module l1d_refill_mem_ctrl #(
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY        = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDR,
  input  logic        LOAD,
  input  logic        STORE,
  input  logic        VALID,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        ACK_ADDR,
  output logic [3:0]  ACK_DATA,
  output logic [31:0] RDATA,
  output logic        ERR
);

  localparam int unsigned Words = 2 ** MEM_DEPTH_LOG2;
  localparam int unsigned BaseW = MEM_DEPTH_LOG2 - 2;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StAck, StWait, StBurst} state_e;

  state_e            state_q, state_d;
  logic [BaseW-1:0]  base_q;
  logic              is_store_q;
  logic [CntW-1:0]   wait_q;
  logic [1:0]        beat_q;
  logic              err_q;
  logic [31:0]       mem [Words];

  logic                      req_ok;
  logic                      req_bad;
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;
  logic                      unused_addr;

  assign req_ok      = VALID & (LOAD ^ STORE);
  assign req_bad     = VALID & LOAD & STORE;
  // Beat index fills the two low word bits, so a burst never leaves its block.
  assign mem_idx     = {base_q, beat_q};
  assign unused_addr = ^{ADDR[31:MEM_DEPTH_LOG2+2], ADDR[3:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      base_q     <= '0;
      is_store_q <= 1'b0;
      wait_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == StIdle) && req_bad;
      if (state_q == StIdle && req_ok) begin
        base_q     <= ADDR[MEM_DEPTH_LOG2+1:4];
        is_store_q <= STORE;
      end
      if (state_q == StAck) begin
        wait_q <= CntW'(LATENCY - 1);
      end else if (state_q == StWait && wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end
      if (state_q == StBurst) begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // Array is not reset; a beat coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == StBurst && is_store_q) begin
      mem[mem_idx] <= WDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_ok) state_d = StAck;
      StAck:   state_d = StWait;
      StWait:  if (wait_q == '0) state_d = StBurst;
      StBurst: if (beat_q == 2'd3) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    READY    = (state_q == StIdle);
    ACK_ADDR = (state_q == StAck);
    ACK_DATA = 4'b0000;
    RDATA    = 32'h0;
    ERR      = err_q;
    if (state_q == StBurst) begin
      ACK_DATA = 4'b0001 << beat_q;
      if (!is_store_q) RDATA = mem[mem_idx];
    end
  end

endmodule
